// File: rtl/conv_z_writeback.sv
// -----------------------------------------------------------------------------
// conv_z_writeback
//
// Purpose:
//   Downstream stage of the convolution controller. Each Z result that the core
//   strobes on writez is captured into a small (addr,data) FIFO. The FIFO is then
//   drained to the shared result-memory write port through a req/gnt handshake.
//   The block counts committed results, flags sticky overflow, and raises done
//   once the core has finished and every queued result has been written.
//
// Ports:
//   clk        in   1          single clock, rising edge
//   rst        in   1          synchronous, active-high reset
//   start      in   1          job-start pulse (honoured in IDLE/DONE only)
//   writez     in   1          one-cycle strobe: z_addr/z_data valid
//   z_addr     in   ADDR_W     result index
//   z_data     in   DATA_W     accumulated result
//   core_done  in   1          core idle level; its rising edge ends the job
//   full       out  1          FIFO full; core must hold off writez
//   mem_req    out  1          write request (FIFO not empty)
//   mem_gnt    in   1          grant; write commits on mem_req && mem_gnt
//   mem_addr   out  ADDR_W     head-entry address (0 when empty)
//   mem_wdata  out  DATA_W     head-entry data (0 when empty)
//   wr_count   out  ADDR_W+1   results committed this job, saturating
//   overflow   out  1          sticky: writez seen while full in RUN
//   busy       out  1          job in progress (RUN or FLUSH)
//   done       out  1          job complete (DONE)
//
// State table:
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | after reset, waiting for first start
//   S_RUN    | core running; results accepted and drained
//   S_FLUSH  | core finished; draining remaining results, writez ignored
//   S_DONE   | all results written; waiting for next start
// -----------------------------------------------------------------------------
module conv_z_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              writez,
  input  logic [ADDR_W-1:0] z_addr,
  input  logic [DATA_W-1:0] z_data,
  input  logic              core_done,
  output logic              full,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ADDR_W:0]  wr_count_q;
  logic             overflow_q;
  logic             busy_q, done_q;
  logic             core_done_q;

  logic empty, full_int;
  logic start_ok, push, drop, pop, done_rise;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign empty     = (count_q == '0);
  assign full_int  = (count_q == CNT_FULL);
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // Push is decided on the pre-edge count, so a full FIFO rejects writez even
  // when the head is being popped in the same cycle.
  assign push      = writez && !full_int && (state_q == S_RUN);
  assign drop      = writez &&  full_int && (state_q == S_RUN);
  assign pop       = !empty && mem_gnt;
  assign done_rise = core_done && !core_done_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)          state_d = S_RUN;
      S_RUN:   if (done_rise)      state_d = S_FLUSH;
      // Leave FLUSH on the edge that empties the FIFO, so done shows up the
      // cycle after the last grant.
      S_FLUSH: if (count_d == '0)  state_d = S_DONE;
      S_DONE:  if (start)          state_d = S_RUN;
      default:                     state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register and registered status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      core_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d == S_RUN) || (state_d == S_FLUSH);
      done_q      <= (state_d == S_DONE);
      core_done_q <= core_done;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers, occupancy, commit counter, overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
    end else if (start_ok) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (!(&wr_count_q)) begin
          wr_count_q <= wr_count_q + (ADDR_W+1)'(1);
        end
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= z_addr;
      data_mem[wr_ptr_q] <= z_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign full      = full_int;
  assign mem_req   = !empty;
  // Head is gated to zero while empty so the port reads 0 after reset.
  assign mem_addr  = empty ? '0 : addr_mem[rd_ptr_q];
  assign mem_wdata = empty ? '0 : data_mem[rd_ptr_q];
  assign wr_count  = wr_count_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_z_writeback.sv
module tb_conv_z_writeback;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;
  localparam int WMAX   = (1 << (ADDR_W + 1)) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, start = 1'b0, writez = 1'b0;
  logic              core_done = 1'b0, mem_gnt = 1'b0;
  logic [ADDR_W-1:0] z_addr = '0;
  logic [DATA_W-1:0] z_data = '0;
  logic              full, mem_req, overflow, busy, done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   wr_count;

  conv_z_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .writez(writez), .z_addr(z_addr),
    .z_data(z_data), .core_done(core_done), .full(full), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wr_count(wr_count), .overflow(overflow), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  typedef enum {P_IDLE, P_RUN, P_FLUSH, P_DONE} phase_t;

  // Reference model: job phase, queue of pending results, commit bookkeeping.
  ent_t   m_fifo[$];
  ent_t   exp_w[$];
  ent_t   dut_w[$];
  phase_t m_phase = P_IDLE;
  int     m_wr = 0;
  bit     m_ov = 0;
  bit     m_cd_prev = 0;

  int checks = 0;
  int failures = 0;

  function automatic bit e_req();
    return m_fifo.size() != 0;
  endfunction
  function automatic logic [ADDR_W-1:0] e_addr();
    return (m_fifo.size() != 0) ? m_fifo[0].a : '0;
  endfunction
  function automatic logic [DATA_W-1:0] e_data();
    return (m_fifo.size() != 0) ? m_fifo[0].d : '0;
  endfunction
  function automatic bit e_full();
    return m_fifo.size() == DEPTH;
  endfunction
  function automatic bit e_busy();
    return (m_phase == P_RUN) || (m_phase == P_FLUSH);
  endfunction
  function automatic bit e_done();
    return m_phase == P_DONE;
  endfunction
  function automatic logic [ADDR_W:0] e_wr();
    return (ADDR_W+1)'(m_wr);
  endfunction

  task automatic model_update();
    bit was_full, pop;
    ent_t e;
    if (rst) begin
      m_fifo.delete(); m_phase = P_IDLE; m_wr = 0; m_ov = 0; m_cd_prev = 0;
      return;
    end
    was_full = (m_fifo.size() == DEPTH);
    pop = (m_fifo.size() != 0) && mem_gnt;
    if (start && (m_phase == P_IDLE || m_phase == P_DONE)) begin
      m_fifo.delete(); m_wr = 0; m_ov = 0; m_phase = P_RUN;
    end else begin
      if (pop) begin
        exp_w.push_back(m_fifo.pop_front());
        if (m_wr < WMAX) m_wr++;
      end
      if (m_phase == P_RUN && writez) begin
        if (was_full) m_ov = 1;
        else begin e.a = z_addr; e.d = z_data; m_fifo.push_back(e); end
      end
      if (m_phase == P_RUN && core_done && !m_cd_prev) m_phase = P_FLUSH;
      else if (m_phase == P_FLUSH && m_fifo.size() == 0) m_phase = P_DONE;
    end
    m_cd_prev = core_done;
  endtask

  // One clock: record any commit seen on the port, advance the model, settle.
  task automatic step();
    ent_t e;
    @(negedge clk);
    if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
      e.a = mem_addr; e.d = mem_wdata; dut_w.push_back(e);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic start_job();
    start = 1'b1; core_done = 1'b0; writez = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic finish_job();
    writez = 1'b0; mem_gnt = 1'b1; core_done = 1'b1;
    for (int k = 0; k < 40 && done !== 1'b1; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL reset_head got=%0h/%0h exp=0/0", mem_addr, mem_wdata); end
    checks++; if (wr_count !== '0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%0b/%0b exp=0/0", busy, done); end
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("FAIL idle_after_reset got busy=%0b req=%0b exp=0/0", busy, mem_req); end
  endtask

  task automatic test_basic();
    dut_w.delete(); exp_w.delete();
    start_job();
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL basic_busy got=%0b/%0b exp=1/0", busy, done); end
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      z_addr = ADDR_W'(i); z_data = DATA_W'(10 + i); writez = 1'b1;
      step();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_wdata !== DATA_W'(10 + i)) begin
        failures++; $display("FAIL basic_latency%0d got req=%0b addr=%0d data=%0d exp 1/%0d/%0d", i, mem_req, mem_addr, mem_wdata, i, 10 + i);
      end
    end
    finish_job();
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_done got done=%0b busy=%0b exp=1/0", done, busy); end
    checks++; if (wr_count !== 7'd4 || overflow !== 1'b0) begin failures++; $display("FAIL basic_counts got wr=%0d ov=%0b exp=4/0", wr_count, overflow); end
    checks++;
    if (dut_w.size() != 4) begin failures++; $display("FAIL basic_writes got=%0d exp=4", dut_w.size()); end
    else for (int i = 0; i < 4; i++)
      if (dut_w[i].a !== ADDR_W'(i) || dut_w[i].d !== DATA_W'(10 + i)) begin
        failures++; $display("FAIL basic_order%0d got=%0d/%0d exp=%0d/%0d", i, dut_w[i].a, dut_w[i].d, i, 10 + i);
      end
  endtask

  task automatic test_overflow_restart();
    logic [DATA_W-1:0] dat [5];
    dut_w.delete(); exp_w.delete();
    start_job();
    mem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dat[i] = $urandom;
      z_addr = ADDR_W'(i); z_data = dat[i]; writez = 1'b1;
      step();
      if (i == 3) begin
        checks++; if (full !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL ovf_full4 got full=%0b ov=%0b exp=1/0", full, overflow); end
      end
    end
    writez = 1'b0;
    checks++; if (overflow !== 1'b1 || full !== 1'b1 || wr_count !== '0) begin failures++; $display("FAIL ovf_flag got ov=%0b full=%0b wr=%0d exp=1/1/0", overflow, full, wr_count); end
    mem_gnt = 1'b1;
    for (int k = 0; k < 10 && mem_req === 1'b1; k++) step();
    checks++; if (wr_count !== 7'd4 || mem_req !== 1'b0) begin failures++; $display("FAIL ovf_drain got wr=%0d req=%0b exp=4/0", wr_count, mem_req); end
    checks++;
    if (dut_w.size() != 4) begin failures++; $display("FAIL ovf_writes got=%0d exp=4", dut_w.size()); end
    else for (int i = 0; i < 4; i++)
      if (dut_w[i].a !== ADDR_W'(i) || dut_w[i].d !== dat[i]) begin
        failures++; $display("FAIL ovf_order%0d got=%0d/%0h exp=%0d/%0h", i, dut_w[i].a, dut_w[i].d, i, dat[i]);
      end
    finish_job();
    checks++; if (done !== 1'b1 || wr_count !== 7'd4 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_done got done=%0b wr=%0d ov=%0b exp=1/4/1", done, wr_count, overflow); end
    start_job();
    checks++; if (wr_count !== '0 || overflow !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL restart got wr=%0d ov=%0b busy=%0b done=%0b exp=0/0/1/0", wr_count, overflow, busy, done);
    end
    finish_job();
  endtask

  task automatic test_gnt_toggle();
    bit held;
    logic [ADDR_W-1:0] pa;
    logic [DATA_W-1:0] pd;
    dut_w.delete(); exp_w.delete();
    start_job();
    for (int i = 0; i < 12; i++) begin
      mem_gnt = 1'(i % 2);
      writez = (i < 3); z_addr = ADDR_W'($urandom); z_data = $urandom;
      held = (mem_req === 1'b1) && !mem_gnt; pa = mem_addr; pd = mem_wdata;
      step();
      if (held) begin
        checks++; if (mem_addr !== pa || mem_wdata !== pd) begin failures++; $display("FAIL toggle_hold got=%0h/%0h exp=%0h/%0h", mem_addr, mem_wdata, pa, pd); end
      end
      checks++; if (mem_addr !== e_addr() || mem_wdata !== e_data()) begin failures++; $display("FAIL toggle_head got=%0h/%0h exp=%0h/%0h", mem_addr, mem_wdata, e_addr(), e_data()); end
    end
    writez = 1'b0;
    finish_job();
    checks++;
    if (dut_w.size() != 3 || exp_w.size() != 3) begin failures++; $display("FAIL toggle_count got=%0d exp=3", dut_w.size()); end
    else for (int i = 0; i < 3; i++)
      if (dut_w[i] !== exp_w[i]) begin failures++; $display("FAIL toggle_order%0d got=%0h exp=%0h", i, dut_w[i], exp_w[i]); end
  endtask

  task automatic test_flush_hold();
    int grants;
    dut_w.delete(); exp_w.delete();
    start_job();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      z_addr = ADDR_W'(i + 20); z_data = $urandom; writez = 1'b1; step();
    end
    writez = 1'b0; core_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL flush_wait got busy=%0b done=%0b exp=1/0", busy, done); end
    end
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      mem_gnt = 1'(i % 2);
      step();
      if (mem_gnt) grants++;
      checks++;
      if (done !== ((grants == 3) ? 1'b1 : 1'b0)) begin failures++; $display("FAIL flush_done g=%0d got=%0b exp=%0b", grants, done, grants == 3); end
    end
    checks++; if (wr_count !== 7'd3 || dut_w.size() != 3) begin failures++; $display("FAIL flush_count got wr=%0d n=%0d exp=3/3", wr_count, dut_w.size()); end
  endtask

  task automatic test_reset_flush();
    dut_w.delete(); exp_w.delete();
    start_job();
    mem_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      z_addr = ADDR_W'(i); z_data = $urandom; writez = 1'b1; step();
    end
    writez = 1'b0; core_done = 1'b1; step();
    checks++; if (busy !== 1'b1 || mem_req !== 1'b1) begin failures++; $display("FAIL rstf_pre got busy=%0b req=%0b exp=1/1", busy, mem_req); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_count !== '0) begin
      failures++; $display("FAIL rstf_after got req=%0b busy=%0b done=%0b wr=%0d exp=0/0/0/0", mem_req, busy, done, wr_count);
    end
    mem_gnt = 1'b1;
    for (int i = 0; i < 4; i++) step();
    checks++; if (dut_w.size() != 0 || mem_req !== 1'b0) begin failures++; $display("FAIL rstf_nowrites got n=%0d req=%0b exp=0/0", dut_w.size(), mem_req); end
  endtask

  task automatic test_random();
    dut_w.delete(); exp_w.delete();
    start_job();
    for (int i = 0; i < 600; i++) begin
      writez  = 1'($urandom_range(0, 1));
      z_addr  = ADDR_W'($urandom);
      z_data  = $urandom;
      mem_gnt = ($urandom_range(0, 2) != 0);
      start   = ($urandom_range(0, 40) == 0);
      step();
      checks++;
      if (mem_req !== e_req() || mem_addr !== e_addr() || mem_wdata !== e_data() || full !== e_full() ||
          wr_count !== e_wr() || overflow !== m_ov || busy !== e_busy() || done !== e_done()) begin
        failures++;
        $display("FAIL random_cyc%0d got req=%0b a=%0h d=%0h full=%0b wr=%0d ov=%0b busy=%0b done=%0b exp %0b/%0h/%0h/%0b/%0d/%0b/%0b/%0b",
                 i, mem_req, mem_addr, mem_wdata, full, wr_count, overflow, busy, done,
                 e_req(), e_addr(), e_data(), e_full(), e_wr(), m_ov, e_busy(), e_done());
      end
    end
    start = 1'b0;
    finish_job();
    checks++; if (done !== 1'b1 || wr_count !== e_wr()) begin failures++; $display("FAIL random_end got done=%0b wr=%0d exp=1/%0d", done, wr_count, e_wr()); end
    checks++;
    if (dut_w.size() != exp_w.size()) begin failures++; $display("FAIL random_nwrites got=%0d exp=%0d", dut_w.size(), exp_w.size()); end
    else for (int i = 0; i < exp_w.size(); i++)
      if (dut_w[i] !== exp_w[i]) begin failures++; $display("FAIL random_write%0d got=%0h exp=%0h", i, dut_w[i], exp_w[i]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_restart();
    test_gnt_toggle();
    test_flush_hold();
    test_reset_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
